// File: rtl/draw_line_controller.sv
// Bresenham line rasteriser: a rising edge on go latches the endpoints and emits one
// pixel write per accepted cycle, clipping points outside the drawable area.
//
// state | meaning
// IDLE  | waiting for a go edge; endpoints and colour latched on the edge
// SETUP | one cycle computing deltas, step directions and initial error
// PLOT  | presenting the current point; advances on acceptance or clip
// DONE  | one-cycle done pulse, then back to IDLE
module draw_line_controller #(
    parameter int X_MAX = 639,
    parameter int Y_MAX = 479
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [9:0] start_x,
    input  logic [8:0] start_y,
    input  logic [9:0] end_x,
    input  logic [8:0] end_y,
    input  logic [7:0] color,
    input  logic       go,
    output logic       busy,
    output logic       done,
    output logic [9:0] pix_x,
    output logic [8:0] pix_y,
    output logic [7:0] pix_color,
    output logic       pix_write,
    input  logic       pix_waitrequest
);

    typedef enum logic [1:0] {IDLE, SETUP, PLOT, DONE} state_t;

    state_t             state;
    logic               go_q;
    logic               armed;
    logic [9:0]         x0_l, x1_l;
    logic [8:0]         y0_l, y1_l;
    logic signed [10:0] dx, dy;
    logic               sx_neg, sy_neg;
    logic signed [11:0] err;

    logic               go_edge;
    logic               accept;
    logic               at_end;
    logic [9:0]         abs_dx;
    logic [8:0]         abs_dy;
    logic signed [12:0] e2, dx_w, dy_w;
    logic               step_x, step_y;
    logic [9:0]         next_x;
    logic [8:0]         next_y;
    logic signed [11:0] next_err;

    function automatic logic in_range(input logic [9:0] x, input logic [8:0] y);
        return (32'(x) <= 32'(X_MAX)) && (32'(y) <= 32'(Y_MAX));
    endfunction

    // armed blocks a go level that is already high when reset releases
    assign go_edge = go & ~go_q & armed;
    assign accept  = ~pix_write | ~pix_waitrequest;
    assign at_end  = (pix_x == x1_l) && (pix_y == y1_l);

    always_comb begin
        abs_dx   = (x1_l >= x0_l) ? (x1_l - x0_l) : (x0_l - x1_l);
        abs_dy   = (y1_l >= y0_l) ? (y1_l - y0_l) : (y0_l - y1_l);
        e2       = {err, 1'b0};
        dx_w     = {{2{dx[10]}}, dx};
        dy_w     = {{2{dy[10]}}, dy};
        step_x   = (e2 >= dy_w) && (pix_x != x1_l);
        step_y   = (e2 <= dx_w) && (pix_y != y1_l);
        next_x   = pix_x;
        next_y   = pix_y;
        next_err = err;
        if (step_x) begin
            next_x   = sx_neg ? (pix_x - 10'd1) : (pix_x + 10'd1);
            next_err = next_err + {dy[10], dy};
        end
        if (step_y) begin
            next_y   = sy_neg ? (pix_y - 9'd1) : (pix_y + 9'd1);
            next_err = next_err + {dx[10], dx};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            go_q      <= 1'b0;
            armed     <= 1'b0;
            x0_l      <= '0;
            x1_l      <= '0;
            y0_l      <= '0;
            y1_l      <= '0;
            dx        <= '0;
            dy        <= '0;
            sx_neg    <= 1'b0;
            sy_neg    <= 1'b0;
            err       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pix_x     <= '0;
            pix_y     <= '0;
            pix_color <= '0;
            pix_write <= 1'b0;
        end else begin
            go_q  <= go;
            armed <= 1'b1;
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (go_edge) begin
                        x0_l      <= start_x;
                        y0_l      <= start_y;
                        x1_l      <= end_x;
                        y1_l      <= end_y;
                        pix_color <= color;
                        busy      <= 1'b1;
                        state     <= SETUP;
                    end
                end
                SETUP: begin
                    dx        <= {1'b0, abs_dx};
                    dy        <= 11'd0 - {2'b00, abs_dy};
                    sx_neg    <= (x1_l < x0_l);
                    sy_neg    <= (y1_l < y0_l);
                    err       <= $signed({2'b00, abs_dx}) - $signed({3'b000, abs_dy});
                    pix_x     <= x0_l;
                    pix_y     <= y0_l;
                    pix_write <= in_range(x0_l, y0_l);
                    state     <= PLOT;
                end
                PLOT: begin
                    // a clipped point has pix_write low, so it is accepted at once
                    if (accept) begin
                        if (at_end) begin
                            pix_write <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            state     <= DONE;
                        end else begin
                            pix_x     <= next_x;
                            pix_y     <= next_y;
                            err       <= next_err;
                            pix_write <= in_range(next_x, next_y);
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_draw_line_controller.sv
// Bench for draw_line_controller: a Bresenham point-list model feeds an expected-write
// queue that a per-cycle compare process checks, with directed and random lines.
module tb_draw_line_controller;

    localparam int XM = 639;
    localparam int YM = 479;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [9:0] start_x = '0;
    logic [8:0] start_y = '0;
    logic [9:0] end_x = '0;
    logic [8:0] end_y = '0;
    logic [7:0] color = '0;
    logic       go = 1'b0;
    logic       busy, done, pix_write;
    logic [9:0] pix_x;
    logic [8:0] pix_y;
    logic [7:0] pix_color;
    logic       pix_waitrequest = 1'b0;

    always #5 clk = ~clk;

    draw_line_controller #(.X_MAX(XM), .Y_MAX(YM)) dut (
        .clk(clk), .reset_n(reset_n),
        .start_x(start_x), .start_y(start_y), .end_x(end_x), .end_y(end_y),
        .color(color), .go(go), .busy(busy), .done(done),
        .pix_x(pix_x), .pix_y(pix_y), .pix_color(pix_color),
        .pix_write(pix_write), .pix_waitrequest(pix_waitrequest)
    );

    typedef struct { int x; int y; int c; } pix_t;

    pix_t exp_q[$];
    int   mx[$];
    int   my[$];
    int   n_tests = 0, n_fail = 0;
    int   total_pts = 0, stall_cnt = 0, busy_cnt = 0, acc_count = 0, lines_done = 0;
    int   hold_cnt = 0, prev_x = 0, prev_y = 0, prev_c = 0;
    int   hold_log[16];
    bit   line_active = 0, stalled_prev = 0;
    int   wr_mode = 0, stall_left = 0;

    function automatic void check(string name, int got, int want);
        n_tests++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d want %0d at t=%0t", name, got, want, $time);
        end
    endfunction

    function automatic void check_str(string name, string got, string want);
        n_tests++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %s want %s", name, got, want);
        end
    endfunction

    // Plain Bresenham over integers: every point of the line, clipped or not.
    function automatic void model_line(int x0, int y0, int x1, int y1);
        int x, y, dx, dy, sx, sy, err, e2;
        mx.delete();
        my.delete();
        x = x0; y = y0;
        dx = (x1 >= x0) ? x1 - x0 : x0 - x1;
        dy = -((y1 >= y0) ? y1 - y0 : y0 - y1);
        sx = (x1 >= x0) ? 1 : -1;
        sy = (y1 >= y0) ? 1 : -1;
        err = dx + dy;
        for (int n = 0; n < 4096; n++) begin
            mx.push_back(x);
            my.push_back(y);
            if (x == x1 && y == y1) break;
            e2 = 2 * err;
            if (e2 >= dy && x != x1) begin x += sx; err += dy; end
            if (e2 <= dx && y != y1) begin y += sy; err += dx; end
        end
    endfunction

    function automatic string model_str(bit written_only);
        string s = "";
        for (int i = 0; i < mx.size(); i++)
            if (!written_only || (mx[i] <= XM && my[i] <= YM))
                s = {s, $sformatf("(%0d,%0d)", mx[i], my[i])};
        return s;
    endfunction

    initial begin : wreq_driver
        forever begin
            @(posedge clk);
            #1;
            case (wr_mode)
                1: pix_waitrequest = ($urandom_range(0, 3) == 0);
                2: if (acc_count == 1 && stall_left > 0) begin
                       pix_waitrequest = 1'b1;
                       stall_left--;
                   end else pix_waitrequest = 1'b0;
                default: pix_waitrequest = 1'b0;
            endcase
        end
    end

    always @(negedge clk) begin : compare
        pix_t e;
        if (!reset_n) begin
            stalled_prev = 0;
        end else begin
            if (pix_write) begin
                check("busy_during_write", int'(busy), 1);
                if (stalled_prev) begin
                    check("hold_x", int'(pix_x), prev_x);
                    check("hold_y", int'(pix_y), prev_y);
                    check("hold_color", int'(pix_color), prev_c);
                    hold_cnt++;
                end else hold_cnt = 1;
                if (!pix_waitrequest) begin
                    check("write_expected", int'(exp_q.size() > 0), 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check("pix_x", int'(pix_x), e.x);
                        check("pix_y", int'(pix_y), e.y);
                        check("pix_color", int'(pix_color), e.c);
                    end
                    if (acc_count < 16) hold_log[acc_count] = hold_cnt;
                    acc_count++;
                    stalled_prev = 0;
                end else begin
                    stalled_prev = 1;
                    prev_x = int'(pix_x);
                    prev_y = int'(pix_y);
                    prev_c = int'(pix_color);
                    stall_cnt++;
                end
            end else begin
                if (stalled_prev) check("write_held_while_stalled", int'(pix_write), 1);
                stalled_prev = 0;
            end
            if (line_active && busy) busy_cnt++;
            if (done) begin
                check("done_expected", int'(line_active), 1);
                check("done_all_written", exp_q.size(), 0);
                check("busy_cycles", busy_cnt, 1 + total_pts + stall_cnt);
                check("busy_low_at_done", int'(busy), 0);
                line_active = 0;
                lines_done++;
            end
        end
    end

    task automatic run_line(int x0, int y0, int x1, int y1, int c, bit scramble, bit retrig);
        int   base;
        pix_t p;
        @(posedge clk);
        #1;
        model_line(x0, y0, x1, y1);
        exp_q.delete();
        for (int i = 0; i < mx.size(); i++)
            if (mx[i] <= XM && my[i] <= YM) begin
                p.x = mx[i]; p.y = my[i]; p.c = c;
                exp_q.push_back(p);
            end
        total_pts = mx.size();
        stall_cnt = 0; busy_cnt = 0; acc_count = 0;
        for (int i = 0; i < 16; i++) hold_log[i] = 0;
        base = lines_done;
        line_active = 1;
        start_x = 10'(x0); start_y = 9'(y0); end_x = 10'(x1); end_y = 9'(y1);
        color = 8'(c);
        go = 1'b1;
        @(posedge clk);
        #1;
        go = 1'b0;
        if (scramble) begin
            start_x = 10'($urandom); start_y = 9'($urandom);
            end_x = 10'($urandom); end_y = 9'($urandom); color = 8'($urandom);
        end
        if (retrig) begin
            repeat (3) @(posedge clk);
            #1;
            go = 1'b1;
            @(posedge clk);
            #1;
            go = 1'b0;
        end
        for (int i = 0; i < 5000 && lines_done == base; i++) begin
            @(negedge clk);
            #1;
        end
        check("line_finished_in_time", lines_done - base, 1);
        if (lines_done == base) begin
            line_active = 0;
            exp_q.delete();
        end
    endtask

    task automatic check_outputs_zero();
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_pix_write", int'(pix_write), 0);
        check("rst_pix_x", int'(pix_x), 0);
        check("rst_pix_y", int'(pix_y), 0);
        check("rst_pix_color", int'(pix_color), 0);
    endtask

    initial begin : main
        int x0, y0, x1, y1, base;

        repeat (3) @(negedge clk);
        #1;
        check_outputs_zero();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (2) @(posedge clk);

        model_line(0, 0, 3, 0);
        check_str("model_horizontal", model_str(0), "(0,0)(1,0)(2,0)(3,0)");
        model_line(5, 5, 2, 2);
        check_str("model_diag_reverse", model_str(0), "(5,5)(4,4)(3,3)(2,2)");
        model_line(0, 0, 4, 2);
        check_str("model_shallow", model_str(0), "(0,0)(1,1)(2,1)(3,2)(4,2)");
        model_line(638, 0, 641, 0);
        check_str("model_clip", model_str(1), "(638,0)(639,0)");

        wr_mode = 0;
        run_line(0, 0, 3, 0, 8'h11, 0, 0);
        check("horiz_writes", acc_count, 4);
        check("horiz_busy_cycles", busy_cnt, 5);
        run_line(5, 5, 2, 2, 8'h22, 0, 0);
        check("diag_writes", acc_count, 4);
        run_line(0, 0, 4, 2, 8'h33, 1, 0);
        check("shallow_writes", acc_count, 5);
        run_line(638, 0, 641, 0, 8'h44, 0, 0);
        check("clip_writes", acc_count, 2);

        wr_mode = 2;
        stall_left = 3;
        run_line(0, 0, 3, 0, 8'h55, 0, 0);
        check("stall_hold_px0", hold_log[0], 1);
        check("stall_hold_px1", hold_log[1], 4);
        check("stall_hold_px2", hold_log[2], 1);
        check("stall_writes", acc_count, 4);
        wr_mode = 0;

        run_line(7, 9, 7, 9, 8'h66, 0, 0);
        check("single_pixel_writes", acc_count, 1);

        // go edge while busy is ignored; go edge sampled in DONE is ignored
        run_line(0, 0, 30, 10, 8'h77, 0, 1);
        check("retrig_writes", acc_count, 31);
        go = 1'b1;
        base = lines_done;
        repeat (8) begin
            @(negedge clk);
            #1;
            check("no_start_after_done_edge", int'(busy), 0);
        end
        check("no_extra_line", lines_done - base, 0);
        go = 1'b0;

        wr_mode = 1;
        for (int n = 0; n < 40; n++) begin
            x0 = $urandom_range(0, 1) ? int'($urandom_range(619, 659)) : int'($urandom_range(0, 1023));
            y0 = $urandom_range(0, 1) ? int'($urandom_range(459, 499)) : int'($urandom_range(0, 511));
            x1 = x0 + int'($urandom_range(0, 50)) - 25;
            y1 = y0 + int'($urandom_range(0, 50)) - 25;
            if (x1 < 0) x1 = 0;
            if (x1 > 1023) x1 = 1023;
            if (y1 < 0) y1 = 0;
            if (y1 > 511) y1 = 511;
            run_line(x0, y0, x1, y1, int'($urandom_range(0, 255)), 1, 0);
        end

        // abort mid-line with reset, go held high across release
        wr_mode = 0;
        run_line_abort: begin
            @(posedge clk);
            #1;
            model_line(0, 0, 300, 0);
            exp_q.delete();
            for (int i = 0; i < mx.size(); i++) exp_q.push_back('{x: mx[i], y: my[i], c: 8'h88});
            total_pts = mx.size();
            stall_cnt = 0; busy_cnt = 0; acc_count = 0;
            line_active = 1;
            start_x = 10'd0; start_y = 9'd0; end_x = 10'd300; end_y = 9'd0; color = 8'h88;
            go = 1'b1;
            for (int i = 0; i < 100 && acc_count < 5; i++) begin
                @(negedge clk);
                #1;
            end
            check("abort_reached_mid_line", int'(acc_count >= 5), 1);
            reset_n = 1'b0;
            line_active = 0;
            exp_q.delete();
            #1;
            check_outputs_zero();
            @(negedge clk);
            #1;
            check_outputs_zero();
            @(posedge clk);
            #1;
            reset_n = 1'b1;
            base = lines_done;
            repeat (10) begin
                @(negedge clk);
                #1;
                check("no_start_with_go_held", int'(busy), 0);
            end
            check("no_done_after_abort", lines_done - base, 0);
            go = 1'b0;
        end

        run_line(2, 3, 6, 1, 8'h99, 0, 0);
        check("post_abort_writes", acc_count, 5);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/draw_line_controller.md
DRAW_LINE_CONTROLLER -- requirements
Module: draw_line_controller

Interface
REQ-001 SHALL have parameter X_MAX, default 639, meaning the largest drawable x coordinate.
REQ-002 SHALL have parameter Y_MAX, default 479, meaning the largest drawable y coordinate.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port start_x, input, 10, line start x, driven by a PIO.
REQ-006 SHALL have port start_y, input, 9, line start y.
REQ-007 SHALL have port end_x, input, 10, line end x.
REQ-008 SHALL have port end_y, input, 9, line end y.
REQ-009 SHALL have port color, input, 8, pixel colour.
REQ-010 SHALL have port go, input, 1, level from a PIO; a rising edge requests a line.
REQ-011 SHALL have port busy, output, 1, high while a line is in progress.
REQ-012 SHALL have port done, output, 1, one-cycle pulse when a line completes.
REQ-013 SHALL have port pix_x, output, 10, x of the pixel write.
REQ-014 SHALL have port pix_y, output, 9, y of the pixel write.
REQ-015 SHALL have port pix_color, output, 8, colour of the pixel write.
REQ-016 SHALL have port pix_write, output, 1, pixel write request.
REQ-017 SHALL have port pix_waitrequest, input, 1, stall from the pixel sink.

Function
REQ-018 SHALL register go and detect a rising edge as go==1 with the registered go==0.
REQ-019 SHALL implement the states IDLE, SETUP, PLOT and DONE.
REQ-020 IDLE: on a go edge, SHALL latch start_x, start_y, end_x, end_y and color, and move to SETUP the next cycle. A go edge in any other state SHALL be ignored.
REQ-021 SETUP, one cycle, SHALL compute:
- dx = |x1-x0| and dy = -|y1-y0|, each 11-bit signed;
- sx and sy = +1 or -1, with +1 when the two coordinates are equal;
- err = dx+dy, 12-bit signed;
- the current point = start.
It SHALL then move to PLOT.
REQ-022 PLOT, when the current point is in range (x<=X_MAX and y<=Y_MAX):
- SHALL assert pix_write with pix_x, pix_y and pix_color equal to the current point and colour;
- SHALL hold all four stable while pix_waitrequest is high;
- the write is accepted on a rising edge where pix_write=1 and pix_waitrequest=0.
REQ-023 PLOT, when the current point is out of range, SHALL keep pix_write low and treat the point as accepted in that same cycle (clipping).
REQ-024 On acceptance with the current point equal to the end point, SHALL go to DONE; otherwise it SHALL step using e2 = 2*err (13-bit signed):
- if e2>=dy and x!=x1: x+=sx and err+=dy;
- if e2<=dx and y!=y1: y+=sy and err+=dx;
- both updates SHALL use the pre-step e2 and sum into one new err in the same cycle;
- it SHALL stay in PLOT.
REQ-025 The accepted-write rate SHALL be at most one per cycle, and there SHALL be no idle cycle between consecutive accepted pixels.
REQ-026 busy SHALL be high in SETUP and PLOT and low in IDLE and DONE.
REQ-027 DONE SHALL assert done for exactly one cycle and then return to IDLE. A go edge sampled during DONE SHALL be ignored.
REQ-028 pix_write SHALL never be asserted outside PLOT.
REQ-029 A line whose start equals its end SHALL produce exactly one write.

Reset
REQ-030 While reset_n=0, the block SHALL be in IDLE with busy, done and pix_write at 0, pix_x, pix_y and pix_color at 0, and the registered go at 0.
REQ-031 Reset asserted mid-line SHALL abort it immediately: no done pulse and no further writes.
REQ-032 After reset release, go held high SHALL not start a line; a fresh 0-to-1 transition is required.

Verification
REQ-033 Horizontal: (0,0) to (3,0), waitrequest=0 -> writes (0,0),(1,0),(2,0),(3,0) on 4 consecutive cycles, then done for 1 cycle.
REQ-034 Diagonal reverse: (5,5) to (2,2) -> writes (5,5),(4,4),(3,3),(2,2).
REQ-035 Shallow: (0,0) to (4,2) -> writes (0,0),(1,1),(2,1),(3,2),(4,2).
REQ-036 Stall: waitrequest high for 3 cycles on the 2nd pixel -> pix_x, pix_y and pix_write are held for 4 cycles and there is no duplicate or skipped pixel.
REQ-037 Clip: (638,0) to (641,0) with X_MAX=639 -> only (638,0) and (639,0) are written, and done still pulses.
REQ-038 Single pixel plus re-trigger: (7,9) to (7,9) -> exactly one write. A go edge while busy is ignored. reset_n=0 mid-line -> all outputs are 0 and there is no done pulse.
